// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the counter-width helper.
package shift_add_mult_pkg;

    // FSM state encoding, kept as plain 2-bit constants so that older
    // tools and hand-written netlists can share the same values.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Number of bits needed to count 0..value-1 (ceil(log2(value))).
    // Returns at least 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/nbit_add.sv
// N-bit ripple-carry adder: a chain of full adders, with the final carry
// carry[N] exposed as carry-out so callers get the full N+1-bit sum.
module nbit_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    // carry[i] is the carry into bit i; carry[N] is the carry out of the MSB.
    logic [N:0] carry;

    assign carry[0] = cin_i;

    // One full adder per bit, rippling the carry upwards.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    // The top of the chain, not an index past it.
    assign cout_o = carry[N];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one WIDTH-bit adder reused for WIDTH
// cycles, producing a 2*WIDTH-bit product behind valid/ready handshakes.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;        // multiplicand
    logic [WIDTH-1:0] q_q, q_d;        // multiplier, shifted out as product low half fills in
    logic [WIDTH-1:0] p_hi_q, p_hi_d;  // product high half / running partial sum
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = q_q[0] ? m_q : '0;

    nbit_add #(.N(WIDTH)) u_add (
        .a_i   (p_hi_q),
        .b_i   (addend),
        .cin_i (1'b0),
        .sum_o (sum),
        .cout_o(cout)
    );

    // Next-state logic: accept in IDLE, one shift-add step per CALC cycle,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        p_hi_d  = p_hi_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    q_d     = b;
                    p_hi_d  = '0;
                    count_d = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // {P_hi,Q} <= {c,sum,Q} >> 1; the carry-out becomes the new MSB.
                p_hi_d  = {cout, sum[WIDTH-1:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            p_hi_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            p_hi_q  <= p_hi_d;
            count_q <= count_d;
        end
    end

    // in_ready is gated by rst directly so it drops without waiting for a clock.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = out_valid ? {p_hi_q, q_q} : '0;

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned multiplier built on the team's N-bit ripple-carry adder.
- Reuses one WIDTH-bit adder for WIDTH clock cycles and produces a 2*WIDTH-bit product, instead of instantiating a full array multiplier.
- Valid/ready handshake on both input and output.
- Sits between an operand source (switch/register front-end) and a result consumer (display or next lab stage).

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands a/b presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer takes product
- product  output  2*WIDTH  a*b, unsigned
- busy  output  1  high in CALC or DONE

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high; all registers clear immediately on assertion.
- Reset values:
  - state=IDLE, product=0, out_valid=0, busy=0, counter=0.
  - in_ready is forced 0 while rst=1, and is 1 in IDLE once rst=0.
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge: M<=a, Q<=b, P_hi<=0, carry<=0, count<=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each edge performs one step, then count<=count+1:
    - sum = P_hi + (Q[0] ? M : 0), computed by the adder with cin=0, giving a WIDTH+1-bit result {c,sum}.
    - {P_hi,Q} <= {c,sum,Q} >> 1.
    - On the edge where count==WIDTH-1, go to DONE.
  - DONE: out_valid=1, product={P_hi,Q}, held stable until out_valid&&out_ready, then go to IDLE.
- Latency:
  - out_valid rises exactly WIDTH cycles after the accept edge (8 for the default).
  - No same-cycle bypass: in_ready returns one cycle after the output handshake.
  - Minimum initiation interval is WIDTH+2 cycles.
- Operands are registered at accept. Changes on a/b/in_valid outside IDLE are ignored.
- out_ready is ignored outside DONE. If out_ready is already high on entering DONE, out_valid is high for exactly one cycle.
- Width rules:
  - The adder carry-out must be kept (WIDTH+1 bits).
  - The maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits, with no overflow or truncation.
- Zero operands still take the full WIDTH cycles; there is no early termination.
- Reset mid-CALC or mid-DONE: the operation is aborted, all outputs return to reset values, and no out_valid is produced for the aborted operation.

Decomposition:
- Shared header/package shift_add_mult_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2
  - the count width function clog2(WIDTH).
- One sub-module: nbit_add with N=WIDTH, instantiated once for the P_hi + M step.
  - Its carry-out must be verified to be carry[N], not an out-of-range index.
  - Any defect found there is fixed in nbit_add itself, not worked around in this block.
- FSM, counter and shift register stay in shift_add_mult.

Test Plan:
- Basic multiply: reset, then a=8'd13, b=8'd11 with in_valid=1 and out_ready=1 → out_valid rises 8 cycles after accept, product=16'd143, out_valid high 1 cycle, in_ready returns 1 the following cycle.
- Carry path at the extremes: a=8'hFF, b=8'hFF → product=16'hFE01. Then a=8'h80, b=8'h02 → product=16'h0100.
- Zero operands: a=0, b=8'hA5 → product=0. Then a=8'hA5, b=0 → product=0. Both still take 8 cycles and busy=1 throughout.
- Output backpressure and input isolation:
  - a=7, b=6 with out_ready=0 for 5 cycles in DONE → product=16'd42 held stable, in_ready=0.
  - in_valid=1 with a=99 during CALC/DONE is ignored.
  - Raising out_ready completes the transfer, and the next operation accepts the new operands.
- Reset mid-operation: assert rst in CALC cycle 3 → outputs clear asynchronously, no stale out_valid. After release, a=3, b=5 → product=16'd15.
- Randomised back-to-back: 1000 random a/b pairs with in_valid always high and random out_ready → every product equals a*b against the reference model, and a new operation is never accepted before the previous output handshake.
